// File: rtl/lif_post_neuron_if.sv
// Spike-input / neuron-state bundle between the STDP weight stage and the LIF neuron.
// The master drives spikes, weights and enable; the slave (neuron) returns its registered state.
interface lif_post_neuron_if #(
  parameter int NUM_PRE = 4,
  parameter int W_WIDTH = 4,
  parameter int V_WIDTH = 8
);
  logic [NUM_PRE-1:0]         pre_spike;
  logic [NUM_PRE*W_WIDTH-1:0] weight;
  logic                       enable;
  logic                       post_spike;
  logic [V_WIDTH-1:0]         membrane;
  logic                       refractory;
  logic [7:0]                 spike_count;

  modport master (
    output pre_spike, weight, enable,
    input  post_spike, membrane, refractory, spike_count
  );

  modport slave (
    input  pre_spike, weight, enable,
    output post_spike, membrane, refractory, spike_count
  );
endinterface

// File: rtl/lif_post_neuron.sv
// Leaky integrate-and-fire neuron: weighted spike sum into a leaky membrane, fire on threshold, then refractory.
// All outputs registered; post_spike follows the crossing edge by one cycle; no backpressure, enable only gates advance.
module lif_post_neuron #(
  parameter int NUM_PRE       = 4,
  parameter int W_WIDTH       = 4,
  parameter int V_WIDTH       = 8,
  parameter int THRESHOLD     = 32,
  parameter int LEAK_SHIFT    = 3,
  parameter int REFRAC_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  lif_post_neuron_if.slave bus
);

  localparam int SUM_W = W_WIDTH + $clog2(NUM_PRE + 1);
  localparam int EXT_W = ((V_WIDTH > SUM_W) ? V_WIDTH : SUM_W) + 1;
  localparam int CNT_W = (REFRAC_CYCLES < 2) ? 1 : $clog2(REFRAC_CYCLES + 1);

  localparam logic [V_WIDTH-1:0] V_MAX       = '1;
  localparam logic [V_WIDTH-1:0] THR         = V_WIDTH'(THRESHOLD);
  localparam logic [CNT_W-1:0]   REFRAC_INIT = CNT_W'(REFRAC_CYCLES);

  typedef enum logic [1:0] {
    S_INTEGRATE,
    S_FIRE,
    S_REFRAC
  } state_t;

  state_t             state;
  logic [V_WIDTH-1:0] v;
  logic               post_q;
  logic               refr_q;
  logic [CNT_W-1:0]   refrac_cnt;
  logic [7:0]         spike_cnt;

  logic [SUM_W-1:0]   sum;
  logic [EXT_W-1:0]   v_wide;
  logic [V_WIDTH-1:0] v_next;

  // Neuron 0 sits in the MSBs of the packed weight bus.
  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_PRE; i++) begin
      if (bus.pre_spike[i]) begin
        sum = sum + SUM_W'(bus.weight[(NUM_PRE-1-i)*W_WIDTH +: W_WIDTH]);
      end
    end
    v_wide = EXT_W'(v) - EXT_W'(v >> LEAK_SHIFT) + EXT_W'(sum);
    v_next = (v_wide > EXT_W'(V_MAX)) ? V_MAX : v_wide[V_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_INTEGRATE;
      v          <= '0;
      post_q     <= 1'b0;
      refr_q     <= 1'b0;
      refrac_cnt <= '0;
      spike_cnt  <= '0;
    end else begin
      case (state)
        S_INTEGRATE: begin
          post_q <= 1'b0;
          if (bus.enable) begin
            if (v_next >= THR) begin
              v      <= '0;
              post_q <= 1'b1;
              state  <= S_FIRE;
              if (spike_cnt != 8'hFF) spike_cnt <= spike_cnt + 8'd1;
            end else begin
              v <= v_next;
            end
          end
        end
        // FIRE advances regardless of enable so the pulse is always one cycle wide.
        S_FIRE: begin
          post_q <= 1'b0;
          v      <= '0;
          if (REFRAC_CYCLES == 0) begin
            state <= S_INTEGRATE;
          end else begin
            state      <= S_REFRAC;
            refrac_cnt <= REFRAC_INIT;
            refr_q     <= 1'b1;
          end
        end
        S_REFRAC: begin
          v <= '0;
          if (bus.enable) begin
            if (refrac_cnt == CNT_W'(1)) begin
              state      <= S_INTEGRATE;
              refr_q     <= 1'b0;
              refrac_cnt <= '0;
            end else begin
              refrac_cnt <= refrac_cnt - CNT_W'(1);
            end
          end
        end
        default: state <= S_INTEGRATE;
      endcase
    end
  end

  assign bus.post_spike  = post_q;
  assign bus.membrane    = v;
  assign bus.refractory  = refr_q;
  assign bus.spike_count = spike_cnt;

endmodule
